// File: rtl/jpeg_pkg.sv
// Shared JPEG decoder types: channel tags, MCU geometry, pixel and block types.
package jpeg_pkg;

    localparam int PIX_W   = 9;
    localparam int CH_W    = 2;
    localparam int MCU_DIM = 16;
    localparam int BLK_DIM = 8;

    typedef enum logic [1:0] {
        CH_Y  = 2'd0,
        CH_CB = 2'd1,
        CH_CR = 2'd2
    } ch_e;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    typedef logic [PIX_W-1:0] pix_t;
    typedef pix_t [BLK_DIM-1:0][BLK_DIM-1:0] blk_t;

endpackage

// File: rtl/mcu_bank.sv
// One 16x16 Y/Cb/Cr MCU store: quadrant-granular writes, per-pixel async read.
module mcu_bank
    import jpeg_pkg::*;
(
    input  logic          clk,
    input  logic          y_we,
    input  logic [1:0]    y_quad,
    input  blk_t          y_blk,
    input  logic          cb_we,
    input  logic          cr_we,
    input  blk_t [3:0]    c_blk,
    input  logic [3:0]    row,
    input  logic [3:0]    col,
    output pix_t          y,
    output pix_t          cb,
    output pix_t          cr
);

    pix_t y_mem  [MCU_DIM][MCU_DIM];
    pix_t cb_mem [MCU_DIM][MCU_DIM];
    pix_t cr_mem [MCU_DIM][MCU_DIM];

    always_ff @(posedge clk) begin
        for (int r = 0; r < BLK_DIM; r++) begin
            for (int c = 0; c < BLK_DIM; c++) begin
                if (y_we)
                    y_mem[{y_quad[1], 3'(r)}][{y_quad[0], 3'(c)}] <= y_blk[r][c];
                for (int q = 0; q < 4; q++) begin
                    if (cb_we)
                        cb_mem[4'((q / 2) * 8 + r)][4'((q % 2) * 8 + c)] <= c_blk[q][r][c];
                    if (cr_we)
                        cr_mem[4'((q / 2) * 8 + r)][4'((q % 2) * 8 + c)] <= c_blk[q][r][c];
                end
            end
        end
    end

    assign y  = y_mem[row][col];
    assign cb = cb_mem[row][col];
    assign cr = cr_mem[row][col];

endmodule

// File: rtl/mcu_assembler.sv
// Gathers a 4:2:0 MCU (4 Y quadrants, full Cb/Cr) and streams 256 raster pixels.
// Define MCU_PINGPONG_EN for two banks so one fills while the other drains.
module mcu_assembler
    import jpeg_pkg::*;
#(
    parameter int PIX_W = 9,
    parameter int CH_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       valid_in,
    input  logic [CH_W-1:0]  ch_in,
    input  blk_t             block_1_in,
    input  blk_t             block_2_in,
    input  blk_t             block_3_in,
    input  blk_t             block_4_in,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] pix_y,
    output logic [PIX_W-1:0] pix_cb,
    output logic [PIX_W-1:0] pix_cr,
    output logic [3:0]       pix_row,
    output logic [3:0]       pix_col,
    output logic             out_last,
    output logic             err
);

`ifdef MCU_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam logic PTR_STEP = 1'(NB - 1);

    state_e [NB-1:0]      st, st_n;
    logic [NB-1:0][2:0]   y_cnt, y_cnt_n;
    logic [NB-1:0]        cb_got, cb_got_n;
    logic [NB-1:0]        cr_got, cr_got_n;
    logic [NB-1:0]        y_we, cb_we, cr_we;
    logic                 fp, fp_n, dp, dp_n;
    logic [7:0]           p, p_n;
    logic                 err_n;
    logic                 fire, any_in, y_ok, c_ok, dup;
    pix_t                 rd_y [NB];
    pix_t                 rd_cb [NB];
    pix_t                 rd_cr [NB];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NB; b++) st[b] <= FILL;
            y_cnt  <= '0;
            cb_got <= '0;
            cr_got <= '0;
            fp     <= 1'b0;
            dp     <= 1'b0;
            p      <= '0;
            err    <= 1'b0;
        end else begin
            st     <= st_n;
            y_cnt  <= y_cnt_n;
            cb_got <= cb_got_n;
            cr_got <= cr_got_n;
            fp     <= fp_n;
            dp     <= dp_n;
            p      <= p_n;
            err    <= err_n;
        end
    end

    always_comb begin
        st_n     = st;
        y_cnt_n  = y_cnt;
        cb_got_n = cb_got;
        cr_got_n = cr_got;
        fp_n     = fp;
        dp_n     = dp;
        p_n      = p;
        err_n    = err;
        y_we     = '0;
        cb_we    = '0;
        cr_we    = '0;
        in_ready  = (st[fp] == FILL);
        out_valid = (st[dp] == DRAIN);
        fire      = out_valid && out_ready;
        any_in    = |valid_in;
        y_ok = (ch_in == CH_Y) && (valid_in == 4'b0001) && (y_cnt[fp] != 3'd4);
        c_ok = ((ch_in == CH_CB) || (ch_in == CH_CR)) && (valid_in == 4'b1111);
        dup  = ((ch_in == CH_CB) && cb_got[fp]) || ((ch_in == CH_CR) && cr_got[fp]);

        if (fire) begin
            p_n = p + 8'd1;
            if (p == 8'hFF) begin
                st_n[dp]     = FILL;
                y_cnt_n[dp]  = '0;
                cb_got_n[dp] = 1'b0;
                cr_got_n[dp] = 1'b0;
                dp_n         = dp ^ PTR_STEP;
            end
        end

        // Fill and drain never target the same bank in the same cycle.
        if (any_in) begin
            if (!in_ready || !(y_ok || c_ok)) begin
                err_n = 1'b1;
            end else begin
                if (y_ok) begin
                    y_we[fp]    = 1'b1;
                    y_cnt_n[fp] = y_cnt[fp] + 3'd1;
                end else if (ch_in == CH_CB) begin
                    cb_we[fp]    = 1'b1;
                    cb_got_n[fp] = 1'b1;
                end else begin
                    cr_we[fp]    = 1'b1;
                    cr_got_n[fp] = 1'b1;
                end
                if (c_ok && dup) err_n = 1'b1;
                if (y_cnt_n[fp] == 3'd4 && cb_got_n[fp] && cr_got_n[fp]) begin
                    st_n[fp] = DRAIN;
                    fp_n     = fp ^ PTR_STEP;
                end
            end
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        mcu_bank u_bank (
            .clk    (clk),
            .y_we   (y_we[b]),
            .y_quad (y_cnt[b][1:0]),
            .y_blk  (block_1_in),
            .cb_we  (cb_we[b]),
            .cr_we  (cr_we[b]),
            .c_blk  ({block_4_in, block_3_in, block_2_in, block_1_in}),
            .row    (p[7:4]),
            .col    (p[3:0]),
            .y      (rd_y[b]),
            .cb     (rd_cb[b]),
            .cr     (rd_cr[b])
        );
    end

    // Gate reads so outputs are zero (not unwritten memory) when idle.
    assign pix_y    = out_valid ? rd_y[dp]  : '0;
    assign pix_cb   = out_valid ? rd_cb[dp] : '0;
    assign pix_cr   = out_valid ? rd_cr[dp] : '0;
    assign pix_row  = p[7:4];
    assign pix_col  = p[3:0];
    assign out_last = out_valid && (p == 8'hFF);

endmodule

// File: tb/tb_mcu_assembler.sv
// Self-checking bench for mcu_assembler: random MCUs against a raster reference model.
module tb_mcu_assembler;
    import jpeg_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] valid_in;
    logic [1:0] ch_in;
    blk_t       b1, b2, b3, b4;
    logic       in_ready, out_valid, out_ready;
    pix_t       pix_y, pix_cb, pix_cr;
    logic [3:0] pix_row, pix_col;
    logic       out_last, err;

    int checks = 0;
    int errors = 0;

    blk_t ym [4];
    blk_t cbm [4];
    blk_t crm [4];

    always #5 clk = ~clk;

    mcu_assembler #(.PIX_W(9), .CH_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .ch_in      (ch_in),
        .block_1_in (b1),
        .block_2_in (b2),
        .block_3_in (b3),
        .block_4_in (b4),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pix_y      (pix_y),
        .pix_cb     (pix_cb),
        .pix_cr     (pix_cr),
        .pix_row    (pix_row),
        .pix_col    (pix_col),
        .out_last   (out_last),
        .err        (err)
    );

    // Reference: pixel (r,c) comes from quadrant (r/8)*2 + c/8 at offset (r%8, c%8).
    function automatic logic [35:0] ref_pix(input int idx);
        int r, c, q;
        r = idx / 16;
        c = idx % 16;
        q = (r / 8) * 2 + (c / 8);
        return {ym[q][r % 8][c % 8], cbm[q][r % 8][c % 8], crm[q][r % 8][c % 8],
                4'(r), 4'(c), (idx == 255)};
    endfunction

    function automatic blk_t rand_blk();
        blk_t b;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[r][c] = 9'($urandom);
        return b;
    endfunction

    task automatic gen(input bit cst);
        for (int q = 0; q < 4; q++) begin
            if (cst) begin
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++) begin
                        ym[q][r][c]  = 9'(10 * (q + 1));
                        cbm[q][r][c] = 9'd100;
                        crm[q][r][c] = 9'd200;
                    end
            end else begin
                ym[q]  = rand_blk();
                cbm[q] = rand_blk();
                crm[q] = rand_blk();
            end
        end
    endtask

    task automatic send(input logic [3:0] v, input logic [1:0] ch,
                        input blk_t x1, input blk_t x2, input blk_t x3, input blk_t x4);
        @(negedge clk);
        valid_in = v;
        ch_in    = ch;
        b1 = x1; b2 = x2; b3 = x3; b4 = x4;
        @(negedge clk);
        valid_in = 4'b0000;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        valid_in  = 4'b0000;
        ch_in     = 2'd0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Item codes: 0..3 = Y in arrival order, 4 = Cb, 5 = Cr.
    task automatic fill(input int order, input bit bad);
        int seq [6];
        if (order == 0) seq = '{0, 1, 2, 3, 4, 5};
        else            seq = '{5, 0, 4, 1, 2, 3};
        for (int i = 0; i < 6; i++) begin
            if (bad && i == 2) begin
                send(4'b0011, 2'd0, rand_blk(), rand_blk(), rand_blk(), rand_blk());
                checks++;
                if (err !== 1'b1 || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL bad_valid err=%b in_ready=%b required 1 1", err, in_ready);
                end
            end
            if (i == 5) begin
                checks++;
                if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL pre_final out_valid=%b in_ready=%b required 0 1",
                             out_valid, in_ready);
                end
            end
            if (seq[i] < 4)
                send(4'b0001, 2'd0, ym[seq[i]], rand_blk(), rand_blk(), rand_blk());
            else if (seq[i] == 4)
                send(4'b1111, 2'd1, cbm[0], cbm[1], cbm[2], cbm[3]);
            else
                send(4'b1111, 2'd2, crm[0], crm[1], crm[2], crm[3]);
        end
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL latency out_valid=%b in_ready=%b required 1 0", out_valid, in_ready);
        end
    endtask

    // mode: 0 always ready, 1 ready 1-0-0-1, 2 random, 3 inject Y mid-drain, 4 reset at 100
    task automatic drain(input int mode, input bit exp_err, input string name);
        int idx = 0;
        int cyc = 0;
        bit rdy;
        logic [35:0] got, want;
        while (idx < 256 && cyc < 3000) begin
            if (mode == 4 && idx == 100) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if (out_valid !== 1'b0 || err !== 1'b0) begin
                    errors++;
                    $display("FAIL %s async_reset out_valid=%b err=%b required 0 0",
                             name, out_valid, err);
                end
                out_ready = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            case (mode)
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                2:       rdy = 1'($urandom);
                default: rdy = 1'b1;
            endcase
            out_ready = rdy;
            if (mode == 3 && cyc == 20) begin
                valid_in = 4'b0001;
                ch_in    = 2'd0;
                b1       = rand_blk();
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s in_ready_drain got=%b required 0", name, in_ready);
                end
            end
            if (mode == 3 && cyc == 21) begin
                valid_in = 4'b0000;
                checks++;
                if (err !== 1'b1) begin
                    errors++;
                    $display("FAIL %s err_drain got=%b required 1", name, err);
                end
            end
            checks++;
            got  = {pix_y, pix_cb, pix_cr, pix_row, pix_col, out_last};
            want = ref_pix(idx);
            if (out_valid !== 1'b1 || got !== want) begin
                errors++;
                $display("FAIL %s pixel %0d valid=%b got=%h required %h",
                         name, idx, out_valid, got, want);
            end
            @(negedge clk);
            if (rdy) idx++;
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (idx != 256 || out_valid !== 1'b0 || in_ready !== 1'b1 || err !== exp_err) begin
            errors++;
            $display("FAIL %s end handshakes=%0d out_valid=%b in_ready=%b err=%b required 256 0 1 %b",
                     name, idx, out_valid, in_ready, err, exp_err);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0 || out_last !== 1'b0 ||
            pix_row !== 4'd0 || pix_col !== 4'd0 || pix_y !== 9'd0 || pix_cb !== 9'd0 ||
            pix_cr !== 9'd0) begin
            errors++;
            $display("FAIL reset ov=%b ir=%b err=%b last=%b row=%0d col=%0d y=%0d required 0 1 0 0 0 0 0",
                     out_valid, in_ready, err, out_last, pix_row, pix_col, pix_y);
        end
    endtask

    task automatic test_basic();
        do_reset();
        gen(1'b1);
        fill(0, 1'b0);
        checks++;
        if (pix_y !== 9'd10 || pix_cb !== 9'd100 || pix_cr !== 9'd200) begin
            errors++;
            $display("FAIL first_pixel got=%0d,%0d,%0d required 10,100,200", pix_y, pix_cb, pix_cr);
        end
        drain(0, 1'b0, "basic");
    endtask

    task automatic test_order();
        do_reset();
        gen(1'b1);
        fill(1, 1'b0);
        drain(2, 1'b0, "order_const");
        gen(1'b0);
        fill(1, 1'b0);
        drain(2, 1'b0, "order_rand");
    endtask

    task automatic test_stall();
        do_reset();
        gen(1'b0);
        fill(0, 1'b0);
        drain(1, 1'b0, "stall");
    endtask

    task automatic test_drain_input();
        do_reset();
        gen(1'b0);
        fill(0, 1'b0);
        drain(3, 1'b1, "drain_input");
    endtask

    task automatic test_bad_valid();
        do_reset();
        gen(1'b0);
        fill(0, 1'b1);
        drain(0, 1'b1, "bad_valid");
    endtask

    task automatic test_reset_mid();
        do_reset();
        gen(1'b0);
        fill(0, 1'b1);
        drain(4, 1'b1, "reset_mid");
        gen(1'b0);
        fill(0, 1'b0);
        drain(0, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            gen(1'b0);
            fill(k % 2, 1'b0);
            drain(2, 1'b0, "back_to_back");
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        valid_in  = 4'b0000;
        ch_in     = 2'd0;
        out_ready = 1'b0;
        b1 = '0; b2 = '0; b3 = '0; b4 = '0;
        test_reset();
        test_basic();
        test_order();
        test_stall();
        test_drain_input();
        test_bad_valid();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
